// File: rtl/rom_command_streamer_if.sv
// ROM read port plus byte stream towards the display controller.
// The master side is the streamer; the slave side is ROM + downstream sink.
interface rom_command_streamer_if #(
    parameter int AW = 5
);
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic          o_valid;
    logic          o_ready;
    logic [7:0]    o_data;
    logic          o_dc;

    modport master (
        output rom_addr,
        input  rom_data,
        output o_valid,
        input  o_ready,
        output o_data,
        output o_dc
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  o_valid,
        output o_ready,
        input  o_data,
        input  o_dc
    );
endinterface

// File: rtl/rom_command_streamer.sv
// Walks a block ROM of 16-bit command words from address 0, emitting command/data
// bytes on a ready/valid stream or pausing for timed delays, until an end word.
module rom_command_streamer #(
    parameter int L          = 32,
    parameter int DELAY_UNIT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    rom_command_streamer_if.master bus
);
    localparam int AW = $clog2(L);
    localparam int UW = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
    localparam logic [AW-1:0] LAST      = AW'(L - 1);
    localparam logic [UW-1:0] UNIT_LAST = UW'(DELAY_UNIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] addr, addr_n;
    logic          valid_q, valid_n;
    logic [7:0]    data_q, data_n;
    logic          dc_q, dc_n;
    logic          done_q, done_n;
    logic          busy_q, busy_n;
    logic [13:0]   tick, tick_n;
    logic [UW-1:0] unit, unit_n;
    logic          adv;

    assign bus.rom_addr = addr;
    assign bus.o_valid  = valid_q;
    assign bus.o_data   = data_q;
    assign bus.o_dc     = dc_q;
    assign busy         = busy_q;
    assign done         = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            addr    <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            dc_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            tick    <= '0;
            unit    <= '0;
        end else begin
            state   <= state_n;
            addr    <= addr_n;
            valid_q <= valid_n;
            data_q  <= data_n;
            dc_q    <= dc_n;
            done_q  <= done_n;
            busy_q  <= busy_n;
            tick    <= tick_n;
            unit    <= unit_n;
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = addr;
        valid_n = valid_q;
        data_n  = data_q;
        dc_n    = dc_q;
        done_n  = done_q;
        tick_n  = tick;
        unit_n  = unit;
        adv     = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    addr_n  = '0;
                    done_n  = 1'b0;
                    state_n = S_FETCH;
                end
            end
            S_FETCH: state_n = S_DECODE;
            S_DECODE: begin
                case (bus.rom_data[15:14])
                    2'b00, 2'b01: begin
                        data_n  = bus.rom_data[7:0];
                        dc_n    = bus.rom_data[14];
                        valid_n = 1'b1;
                        state_n = S_SEND;
                    end
                    2'b10: begin
                        // A zero-length delay costs no WAIT cycles at all.
                        if (bus.rom_data[13:0] != 14'd0) begin
                            tick_n  = bus.rom_data[13:0];
                            unit_n  = '0;
                            state_n = S_WAIT;
                        end else begin
                            adv = 1'b1;
                        end
                    end
                    default: begin
                        done_n  = 1'b1;
                        state_n = S_DONE;
                    end
                endcase
            end
            S_SEND: begin
                if (valid_q && bus.o_ready) begin
                    valid_n = 1'b0;
                    adv     = 1'b1;
                end
            end
            S_WAIT: begin
                if (unit == UNIT_LAST) begin
                    unit_n = '0;
                    tick_n = tick - 14'd1;
                    if (tick == 14'd1)
                        adv = 1'b1;
                end else begin
                    unit_n = unit + UW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Running off the end of the ROM is an implicit end word, never a wrap.
        if (adv) begin
            if (addr == LAST) begin
                done_n  = 1'b1;
                state_n = S_DONE;
            end else begin
                addr_n  = addr + AW'(1);
                state_n = S_FETCH;
            end
        end

        busy_n = (state_n != S_IDLE) && (state_n != S_DONE);
    end
endmodule
